// File: rtl/jtframe_db15_pkg.sv
// Shared constants for the DB15 (SNAC) joystick link emulator: default sizes,
// counter-width helper and the bit map of a player's button word.
package jtframe_db15_pkg;

    localparam int NBITS_DEF = 12;
    localparam int W_DEF     = 2 * NBITS_DEF;

    // Bit positions inside one player's button word.
    localparam int JOY_UP    = 0;
    localparam int JOY_DOWN  = 1;
    localparam int JOY_LEFT  = 2;
    localparam int JOY_RIGHT = 3;
    localparam int JOY_B1    = 4;
    localparam int JOY_B2    = 5;
    localparam int JOY_B3    = 6;
    localparam int JOY_B4    = 7;
    localparam int JOY_B5    = 8;
    localparam int JOY_B6    = 9;
    localparam int JOY_START = 10;
    localparam int JOY_COIN  = 11;

    // Width needed to count 0..w inclusive.
    function automatic int bitcnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/jtframe_db15_sync.sv
// Two-flop synchroniser for one asynchronous link signal, plus a delay flop
// providing single-cycle rise/fall strobes.
module jtframe_db15_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta;
    logic q_d;

    // NOTE: the reset value matches the line's idle level so that releasing
    // reset never manufactures a spurious edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
            q_d  <= RST_VAL;
        end else begin
            // NOTE: non-blocking assignments keep the three flops a true chain;
            // blocking would collapse them into one stage.
            meta <= din;
            q    <= meta;
            q_d  <= q;
        end
    end

    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/jtframe_db15_joyemu.sv
// Device end of the DB15 serial joystick link: a 74HC165-style load/shift chain
// holding both players' buttons, clocked by the host through synchronisers.
module jtframe_db15_joyemu
    import jtframe_db15_pkg::*;
#(
    parameter int   NBITS   = NBITS_DEF,
    parameter bit   INVERT  = 1'b1,
    parameter logic SERIN   = 1'b1,
    parameter int   TIMEOUT = 1000000
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NBITS-1:0]                   joy1,
    input  logic [NBITS-1:0]                   joy2,
    input  logic                               joy_clk,
    input  logic                               joy_load,
    output logic                               joy_data,
    output logic                               frame_done,
    output logic [bitcnt_w(2*NBITS)-1:0]       bitcnt,
    output logic                               active
);

    localparam int W  = 2 * NBITS;
    localparam int CW = bitcnt_w(W);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    logic          clk_s, clk_rise, clk_fall;
    logic          load_s, load_rise, load_fall;
    logic [W-1:0]  shreg;
    logic [TW-1:0] to_cnt;

    jtframe_db15_sync #(.RST_VAL(1'b0)) u_clk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (joy_clk),
        .q     (clk_s),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    jtframe_db15_sync #(.RST_VAL(1'b1)) u_load_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (joy_load),
        .q     (load_s),
        .rise  (load_rise),
        .fall  (load_fall)
    );

    // Clock level and falling edge, and the load release, carry no action.
    logic unused_edges;
    assign unused_edges = &{1'b0, clk_s, clk_fall, load_rise};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '1;
            bitcnt     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Load is level sensitive and outranks a coincident shift edge.
            if (!load_s) begin
                shreg  <= {W{INVERT}} ^ {joy2, joy1};
                bitcnt <= '0;
            end else if (clk_rise) begin
                shreg <= {SERIN, shreg[W-1:1]};
                if (bitcnt != CNT_FULL) begin
                    bitcnt <= bitcnt + 1'b1;
                end
                frame_done <= (bitcnt == CNT_LAST);
            end
        end
    end

    assign joy_data = shreg[0];

    // Link watchdog: any load falling edge re-arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
            active <= 1'b0;
        end else if (load_fall) begin
            to_cnt <= '0;
            active <= 1'b1;
        end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TO_LAST) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtframe_db15_joyemu.sv
// Self-checking bench for jtframe_db15_joyemu: reset, frame streaming, saturation,
// load/clock collision, watchdog, async reset and randomized frames vs a model.
module tb_jtframe_db15_joyemu;

    localparam int NB = 12;
    localparam int W  = 2 * NB;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] joy1 = '0;
    logic [NB-1:0] joy2 = '0;
    logic          joy_clk = 1'b0;
    logic          joy_load = 1'b1;
    logic          joy_data;
    logic          frame_done;
    logic [4:0]    bitcnt;
    logic          active;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    jtframe_db15_joyemu #(
        .NBITS   (NB),
        .INVERT  (1'b1),
        .SERIN   (1'b1),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .joy1       (joy1),
        .joy2       (joy2),
        .joy_clk    (joy_clk),
        .joy_load   (joy_load),
        .joy_data   (joy_data),
        .frame_done (frame_done),
        .bitcnt     (bitcnt),
        .active     (active)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

    typedef struct {
        logic [NB-1:0] j1;
        logic [NB-1:0] j2;
        int            n;
        logic          data;
        int            cnt;
        int            fd;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse();
        joy_clk = 1'b1;
        cycles(4);
        joy_clk = 1'b0;
        cycles(4);
    endtask

    task automatic do_load(input logic [NB-1:0] a, input logic [NB-1:0] b);
        joy1 = a;
        joy2 = b;
        joy_load = 1'b0;
        cycles(4);
        joy_load = 1'b1;
        cycles(4);
    endtask

    // Reference: the wire carries the inverted frame, bit k at position k, then SERIN.
    function automatic logic exp_bit(input logic [NB-1:0] a, input logic [NB-1:0] b, input int k);
        logic [W-1:0] frame;
        frame = ~{b, a};
        return (k < W) ? frame[k] : 1'b1;
    endfunction

    initial begin
        int fd0;
        int n;
        logic [NB-1:0] ra, rb;

        vecs[0] = '{12'h001, 12'h800,  0, 1'b0,  0, 0};
        vecs[1] = '{12'h001, 12'h800,  1, 1'b1,  1, 0};
        vecs[2] = '{12'h001, 12'h800, 23, 1'b0, 23, 0};
        vecs[3] = '{12'h001, 12'h800, 24, 1'b1, 24, 1};
        vecs[4] = '{12'h001, 12'h800, 27, 1'b1, 24, 1};
        vecs[5] = '{12'hFFF, 12'h000,  5, 1'b0,  5, 0};
        vecs[6] = '{12'h000, 12'h000, 12, 1'b1, 12, 0};
        vecs[7] = '{12'h000, 12'h001, 12, 1'b0, 12, 0};
        vecs[8] = '{12'hA5A, 12'h000,  1, 1'b0,  1, 0};

        // Reset state and idle link
        cycles(3);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycles(250);
            check("idle_data", joy_data, 1'b1);
            check("idle_bitcnt", bitcnt, 0);
            check("idle_active", active, 1'b0);
        end

        // Watchdog
        joy_load = 1'b0;
        cycles(3);
        check("active_on_load", active, 1'b1);
        joy_load = 1'b1;
        cycles(47);
        check("active_hold", active, 1'b1);
        cycles(54);
        check("active_timeout", active, 1'b0);
        joy_load = 1'b0;
        cycles(3);
        check("active_reload", active, 1'b1);
        joy_load = 1'b1;
        cycles(4);

        // Reference frame streamed bit by bit
        fd0 = fd_cnt;
        do_load(12'h001, 12'h800);
        for (int k = 0; k < W; k++) begin
            check($sformatf("stream_bit%0d", k), joy_data, (k == 0 || k == 23) ? 1'b0 : 1'b1);
            if (k == W - 1) check("fd_before_last", fd_cnt - fd0, 0);
            pulse();
        end
        check("stream_fd", fd_cnt - fd0, 1);
        check("stream_bitcnt", bitcnt, W);
        for (int k = 0; k < 3; k++) begin
            pulse();
            check("extra_serin", joy_data, 1'b1);
            check("extra_bitcnt", bitcnt, W);
        end
        check("extra_fd", fd_cnt - fd0, 1);

        // Table of frames: data after n shifts, count and frame_done pulses
        foreach (vecs[i]) begin
            fd0 = fd_cnt;
            do_load(vecs[i].j1, vecs[i].j2);
            for (int k = 0; k < vecs[i].n; k++) pulse();
            check($sformatf("vec%0d_data", i), joy_data, vecs[i].data);
            check($sformatf("vec%0d_bitcnt", i), bitcnt, vecs[i].cnt);
            check($sformatf("vec%0d_fd", i), fd_cnt - fd0, vecs[i].fd);
        end

        // Load falling together with a clock rise mid-frame: load wins
        do_load(12'h000, 12'h000);
        for (int k = 0; k < 7; k++) pulse();
        check("coll_pre_bitcnt", bitcnt, 7);
        fd0 = fd_cnt;
        joy1 = 12'h002;
        joy2 = 12'h000;
        joy_load = 1'b0;
        joy_clk = 1'b1;
        cycles(4);
        joy_load = 1'b1;
        cycles(4);
        check("coll_bitcnt", bitcnt, 0);
        check("coll_data", joy_data, 1'b1);
        joy_clk = 1'b0;
        cycles(4);
        pulse();
        check("coll_next_bitcnt", bitcnt, 1);
        check("coll_next_data", joy_data, 1'b0);
        check("coll_fd", fd_cnt - fd0, 0);

        // Randomized frames against the reference model
        for (int it = 0; it < 20; it++) begin
            ra = NB'($urandom);
            rb = NB'($urandom);
            n = $urandom_range(0, 28);
            fd0 = fd_cnt;
            do_load(ra, rb);
            check("rnd_bit0", joy_data, exp_bit(ra, rb, 0));
            for (int k = 1; k <= n; k++) begin
                pulse();
                check($sformatf("rnd%0d_bit%0d", it, k), joy_data, exp_bit(ra, rb, k));
            end
            check("rnd_bitcnt", bitcnt, (n < W) ? n : W);
            check("rnd_fd", fd_cnt - fd0, (n >= W) ? 1 : 0);
        end

        // Asynchronous reset mid-frame
        do_load(12'hFFF, 12'hFFF);
        for (int k = 0; k < 10; k++) pulse();
        check("pre_rst_bitcnt", bitcnt, 10);
        check("pre_rst_data", joy_data, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_data", joy_data, 1'b1);
        check("async_rst_bitcnt", bitcnt, 0);
        check("async_rst_active", active, 1'b0);
        cycles(3);
        rst_n = 1'b1;
        cycles(3);
        for (int k = 0; k < 5; k++) begin
            pulse();
            check("post_rst_ones", joy_data, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jtframe_db15_joyemu.md
Name: jtframe_db15_joyemu

Overview:
- Device-side responder for the serial DB15 (SNAC) joystick link.
- Emulates the adapter's parallel-in/serial-out shift-register chain (74HC165 style): snapshots two players' button words while the host holds JOY_LOAD low, then shifts one bit per JOY_CLK rising edge onto JOY_DATA.
- Used as the far end of the framework's DB15 reader in simulation benches and in loop-back/test builds.
- Runs entirely in the system clock domain; host-driven link signals are asynchronous and are synchronised internally.

Parameters:
- NBITS, 12: bits per player; chain length W = 2*NBITS.
- INVERT, 1: 1 = joy inputs are active-high and are inverted at capture, because the link is active-low.
- SERIN, 1'b1: value shifted into the chain MSB (daisy-chain serial input tie).
- TIMEOUT, 1000000: clk cycles without a load pulse before active drops.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- joy1  in  NBITS  player-1 buttons; bit0 is shifted first.
- joy2  in  NBITS  player-2 buttons; shifted after all of joy1.
- joy_clk  in  1  host shift clock, asynchronous.
- joy_load  in  1  host parallel-load strobe, active-low, asynchronous.
- joy_data  out  1  serial data to host.
- frame_done  out  1  one-cycle pulse when the W-th shift occurs.
- bitcnt  out  $clog2(W+1)  shifts since last load; saturates at W.
- active  out  1  host has issued a load within TIMEOUT cycles.

Behaviour:
- Reset (rst_n=0, async):
  - shreg = all 1s; joy_data = 1; bitcnt = 0; frame_done = 0; active = 0.
  - Sync flops: joy_clk → 0, joy_load → 1. Timeout counter = 0.
- Synchronisers:
  - 2-FF sync on joy_clk and joy_load, plus one delay flop each for edge detection.
  - All decisions use the synchronised values.
- Load (level sensitive):
  - Every cycle load_s==0: shreg ← {joy2, joy1}, XOR all-ones if INVERT.
  - Same cycle: bitcnt ← 0, frame_done ← 0.
  - Inputs keep being re-sampled while load is held low.
- Output: joy_data = shreg[0], registered.
  - Latency from a joy_load low on the pin to joy_data showing the new bit0 is 3 clk.
- Shift:
  - Occurs on a joy_clk rising edge (clk_s & ~clk_d) with load_s==1.
  - shreg ← {SERIN, shreg[W-1:1]}.
  - bitcnt ← min(bitcnt+1, W).
- frame_done: 1 for one cycle on the shift where bitcnt goes W-1 → W. Shifts after that keep sending SERIN and do not pulse again.
- Simultaneous load low and clock rising edge: load wins and the shift is discarded (74HC165 priority).
- Falling edge of joy_clk: no action.
- Timeout counter:
  - Cleared on a falling edge of load_s, which also sets active ← 1.
  - Otherwise increments, saturating at TIMEOUT.
  - On reaching TIMEOUT, active ← 0.
- Reset asserted mid-frame: immediate return to the reset values. The first frame after reset needs a new load.
- Glitch handling: pulses shorter than 2 clk may be missed. This is legal, because the host clocks the link at ≤ clk/8.

Decomposition:
- Package jtframe_db15_pkg:
  - localparams for default NBITS, W, and the bitcnt width function.
  - Bit-position constants for the joystick word: up, down, left, right, b1..b6, start, coin.
- Sub-module jtframe_db15_sync: 2-FF synchroniser with edge-detect outputs (rise, fall). Instantiated twice.

Test Plan:
- Reset release with no host activity → joy_data=1, bitcnt=0, active=0, for 2000 clk.
- INVERT=1, joy1=12'h001, joy2=12'h800, load low for 4 clk, then 24 clock pulses at clk/8 → serial stream is bit0=0, bits1..22=1, bit23=0. frame_done pulses once, on the 24th edge. bitcnt=24.
- After 24 shifts, 3 extra pulses → joy_data=1 (SERIN), bitcnt stays 24, no frame_done.
- joy_load falls in the same synchronised cycle as a joy_clk rise, mid-frame (bitcnt=7) → bitcnt=0, shreg reloaded, no shift applied.
- TIMEOUT=100: one load pulse → active=1 within 3 clk. Then 101 clk with no load → active=0. Next load → active=1.
- rst_n asserted at bitcnt=10 → joy_data=1 and bitcnt=0 asynchronously. After release, clocks without a load shift out only 1s.
